// File: rtl/mmio_bridge_pkg.sv
// Shared constants and types for the MMIO bridge.
// Region codes, RAM geometry, timer offsets, address decode.
package mmio_bridge_pkg;

  localparam logic [3:0] RGN_RAM = 4'h0;
  localparam logic [3:0] RGN_LED = 4'h1;
  localparam logic [3:0] RGN_SW  = 4'h3;
  localparam logic [3:0] RGN_TMR = 4'h4;

  localparam int RAM_DEPTH = 256;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);

  localparam logic TMR_COUNT = 1'b0;
  localparam logic TMR_CTRL  = 1'b1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_CNT,
    SEL_CTRL
  } sel_t;

  function automatic sel_t decode(input logic [15:0] a);
    sel_t s;
    case (a[15:12])
      RGN_RAM: s = SEL_RAM;
      RGN_LED: s = SEL_LED;
      RGN_SW:  s = SEL_SW;
      RGN_TMR: s = (a[0] == TMR_CTRL) ? SEL_CTRL : SEL_CNT;
      default: s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmio_bridge_ram.sv
// 256x16 single-port RAM, synchronous read and write.
// Read returns the old word when written in the same cycle.
module mmio_ram
  import mmio_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [RAM_DEPTH];

  // read-before-write storage array
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mmio_bridge.sv
// MMIO bridge: RAM, LED register, synchronized switches, timer.
// Read data is registered; one cycle latency for every region.
module mmio_bridge
  import mmio_bridge_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic        TIRQ
);

  sel_t        sel;
  sel_t        sel_q;
  logic [15:0] rd_next;
  logic [15:0] rd_q;
  logic [15:0] ram_rdata;
  logic        ram_we;

  logic [9:0]  sw_meta;
  logic [9:0]  sw_sync;

  logic [15:0] reload;
  logic [15:0] count;
  logic        enable;
  logic        autoreload;
  logic        done;
  logic        load_wr;
  logic        ctrl_wr;
  logic        expire;

  assign sel     = decode(ADDR);
  assign ram_we  = W && (sel == SEL_RAM) && !Reset;
  assign load_wr = W && (sel == SEL_CNT);
  assign ctrl_wr = W && (sel == SEL_CTRL);
  assign expire  = enable && (count == 16'd1);
  assign TIRQ    = done;

  mmio_ram u_ram (
    .clk   (Clock),
    .we    (ram_we),
    .addr  (ADDR[RAM_AW-1:0]),
    .wdata (DOUT),
    .rdata (ram_rdata)
  );

  // select the pre-edge value of the addressed register
  always_comb begin
    rd_next = '0;
    case (sel)
      SEL_LED:  rd_next = {6'b0, LEDR};
      SEL_SW:   rd_next = {6'b0, sw_sync};
      SEL_CNT:  rd_next = count;
      SEL_CTRL: rd_next = {13'b0, done, autoreload, enable};
      default:  rd_next = '0;
    endcase
  end

  // registered region code and register read data
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_q <= SEL_NONE;
      rd_q  <= '0;
    end else begin
      sel_q <= sel;
      rd_q  <= rd_next;
    end
  end

  assign DIN = (sel_q == SEL_RAM) ? ram_rdata : rd_q;

  // LED register
  always_ff @(posedge Clock) begin
    if (Reset)
      LEDR <= '0;
    else if (W && (sel == SEL_LED))
      LEDR <= DOUT[9:0];
  end

  // two-flop switch synchronizer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  // timer: load beats countdown, expiry beats done-clear
  always_ff @(posedge Clock) begin
    if (Reset) begin
      reload     <= '0;
      count      <= '0;
      enable     <= 1'b0;
      autoreload <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (load_wr) begin
        reload <= DOUT;
        count  <= DOUT;
      end else if (enable && (count > 16'd1)) begin
        count <= count - 16'd1;
      end else if (expire) begin
        count <= autoreload ? reload : 16'd0;
      end
      if (ctrl_wr) begin
        enable     <= DOUT[0];
        autoreload <= DOUT[1];
        done       <= expire;
      end else if (expire) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 SHALL have port Clock, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port ADDR, input, 16, word address from processor address register.
REQ-004 SHALL have port DOUT, input, 16, write data from processor.
REQ-005 SHALL have port W, input, 1, write strobe; write takes effect on the edge where W=1.
REQ-006 SHALL have port DIN, output, 16, read data to processor.
REQ-007 SHALL have port SW, input, 10, asynchronous slide switches.
REQ-008 SHALL have port LEDR, output, 10, LED register.
REQ-009 SHALL have port TIRQ, output, 1, timer done flag, mirrors status bit 2.

Function
REQ-010 SHALL decode ADDR[15:12]: 0x0 RAM, 0x1 LEDR, 0x3 SW, 0x4 timer; all other regions unmapped.
REQ-011 SHALL implement a 256x16 RAM indexed by ADDR[7:0]; ADDR[11:8] ignored (aliasing).
REQ-012 SHALL provide DIN as a registered value: DIN after edge k equals content at ADDR sampled at edge k (1-cycle read latency, matching the processor wait cycle).
REQ-013 SHALL return 0x0000 on reads of unmapped regions; unmapped writes ignored, no side effects.
REQ-014 SHALL, on RAM read and write to the same address in one cycle, return old data (read-before-write).
REQ-015 SHALL write LEDR <= DOUT[9:0] on W to region 0x1; reads return {6'b0, LEDR}.
REQ-016 SHALL pass SW through a two-flop synchronizer; region 0x3 reads return {6'b0, SW_sync}; writes ignored.
REQ-017 SHALL hold timer registers: LOAD/COUNT at ADDR[0]=0, CTRL/STATUS at ADDR[0]=1 within region 0x4.
REQ-018 SHALL, on write to LOAD, set reload <= DOUT and count <= DOUT; reads return current count.
REQ-019 SHALL, on write to CTRL, set enable <= DOUT[0], autoreload <= DOUT[1], clear done; reads return {13'b0, done, autoreload, enable}.
REQ-020 SHALL, when enable=1 and count>1, decrement count by 1 per cycle.
REQ-021 SHALL, when enable=1 and count==1, set done <= 1 and count <= (autoreload ? reload : 0).
REQ-022 SHALL hold count when enable=0 or count==0 (no wrap-around below zero).
REQ-023 SHALL give a LOAD write priority over decrement/reload in the same cycle.
REQ-024 SHALL give done-set priority over a CTRL-write clear in the same cycle; enable/autoreload still take the written values.
REQ-025 SHALL drive TIRQ = done combinationally from the done register.

Reset
REQ-026 SHALL on Reset=1 clear DIN, LEDR, synchronizer flops, reload, count, enable, autoreload, done to 0.
REQ-027 SHALL not reset RAM contents; RAM writes are suppressed while Reset=1.
REQ-028 SHALL abort any in-flight access on reset; DIN=0 the cycle after reset is sampled.

Structure
REQ-029 SHALL place region codes (0x0, 0x1, 0x3, 0x4), RAM depth 256, and timer register offsets in a shared package.
REQ-030 SHALL implement the RAM as sub-module mmio_ram (synchronous read, synchronous write, 256x16).
REQ-031 SHALL keep the timer and LED/SW logic inside mmio_bridge; read mux selects via a registered region code.

Verification
REQ-032 SHALL cover: write 0x1234 to 0x0005, then read 0x0005 -> DIN=0x1234 one cycle after ADDR; read 0x0105 -> 0x1234 (alias).
REQ-033 SHALL cover: write 0x03FF to 0x1000 -> LEDR=0x3FF next cycle; read 0x1000 -> DIN=0x03FF; read 0x2000 -> DIN=0x0000.
REQ-034 SHALL cover: SW=0x2A5 applied -> read 0x3000 returns 0x02A5 no earlier than 2 cycles after change.
REQ-035 SHALL cover: LOAD=3, CTRL=0x1 -> count 3,2,1,0 on successive cycles, done=1 and TIRQ=1 at 0, count holds 0.
REQ-036 SHALL cover: LOAD=2, CTRL=0x3 -> count 2,1,2,1,...; CTRL write 0x3 on the expiry cycle leaves done=1.
REQ-037 SHALL cover: Reset asserted mid-countdown with LEDR=0x155 -> LEDR=0, count=0, done=0, DIN=0; RAM data written before reset still reads back.
